ch3_wave_player: RTL
====================

Name: ch3_wave_player

Overview:
- Channel 3 playback engine. Consumes the FF1A–FF1E register state written by the CPU through the channel 3 register block.
- Steps the 11-bit frequency timer and walks the 32-nibble wave RAM. Applies the output-level shift and runs the length counter.
- Produces the 4-bit channel 3 DAC code and the channel-active status bit.

Parameters:
- LEN_W, 8, length counter width (FF1B load value).
- FREQ_W, 11, frequency timer width ({FF1E[2:0], FF1D[7:0]}).

Ports:
- cery_2mhz  input  1  APU 2 MHz clock; all state on rising edge.
- napu_reset  input  1  asynchronous active-low reset.
- nff1a_d7  input  1  DAC power, active low (FF1A bit 7 inverted).
- ff1b_wr  input  1  one-cycle strobe: FF1B write.
- len_data  input  8  FF1B data, valid with ff1b_wr.
- ff1c_vol  input  2  {ff1c_d6, ff1c_d5} output level code.
- ff1d_freq  input  8  ff1d_d7..ff1d_d0.
- ff1e_freq  input  3  ff1e_d2..ff1e_d0.
- ff1e_d6  input  1  length enable.
- trig  input  1  one-cycle strobe: FF1E write with bit 7 set.
- len_tick  input  1  one-cycle 256 Hz frame-sequencer strobe.
- wave_rd  output  1  one-cycle wave RAM read request.
- wave_addr  output  4  wave RAM byte address (FF30 + wave_addr).
- wave_data  input  8  wave RAM byte, valid the cycle after wave_rd.
- ch3_out  output  4  DAC code.
- ch3_active  output  1  channel on (NR52 bit 2).

Behaviour:
- Reset (napu_reset=0, async) clears:
  - freq_cnt=0, idx=0, sample_buf=0, len_cnt=0;
  - ch3_active=0, wave_rd=0, wave_addr=0, ch3_out=0.
- Priority per cycle, highest first: DAC off, trig, timer/length events.
- DAC off (nff1a_d7=1):
  - ch3_active<=0 that cycle; trig ignored.
  - freq_cnt and idx hold. len_cnt still accepts ff1b_wr.
- Trigger (trig=1, DAC on):
  - freq_cnt<={ff1e_freq,ff1d_freq}; idx<=0; ch3_active<=1.
  - sample_buf is NOT refreshed, so the stale byte plays until the first fetch.
  - If len_cnt==8'hFF, len_cnt<=0.
  - Retrigger while active restarts identically.
- Frequency timer, while ch3_active=1 and no trig:
  - freq_cnt==11'h7FF: freq_cnt<=reload value sampled this cycle; idx<=idx+1 (5-bit, 31 wraps to 0). Next cycle wave_rd=1 with wave_addr=new idx[4:1].
  - Otherwise freq_cnt<=freq_cnt+1.
  - Period = (2048 - freq) cycles per nibble. With freq=11'h7FF, idx advances every cycle.
  - Register changes take effect only at the next reload.
- Fetch:
  - sample_buf<=wave_data exactly one cycle after wave_rd=1. wave_rd is high for one cycle only.
  - Nibble select: idx[0]==0 takes sample_buf[7:4], idx[0]==1 takes sample_buf[3:0].
- Output, registered, 1-cycle latency from sample_buf/idx/ff1c_vol:
  - vol 00: 0.
  - vol 01: nibble.
  - vol 10: nibble>>1.
  - vol 11: nibble>>2.
  - ch3_out=0 whenever ch3_active=0.
- Length:
  - ff1b_wr: len_cnt<=len_data, regardless of active.
  - len_tick && ff1e_d6: len_cnt<=len_cnt+1. On 8'hFF->8'h00, ch3_active<=0 unless trig in the same cycle.
  - ff1b_wr and len_tick in the same cycle: the write wins.
  - Counting continues while inactive.
- Reset mid-playback: immediate return to reset values; no wave_rd glitch.

Decomposition:
- Package ch3_pkg:
  - enum vol_code_t {VOL_MUTE, VOL_100, VOL_50, VOL_25};
  - localparams FREQ_MAX=11'h7FF, IDX_W=5.
  - function vol_shift(nibble, code).
- Sub-module ch3_length_ctr: len_cnt, load/tick/expire logic, and the expire pulse to the top.

Test Plan:
- Reset with napu_reset=0 mid-playback -> all outputs 0 immediately; after release, ch3_active stays 0 until trig.
- Wave RAM FF30=8'h12, FF31=8'h34; freq=11'h7FE; vol=01; trig -> freq period 2 cycles:
  - first wave_rd at addr 0;
  - ch3_out sequence 2,3,4 as idx goes 1,2,3;
  - before the first fetch, stale sample_buf (0 after reset) is output.
- Same setup with vol=10 and wave byte 8'hF8 -> outputs 7 then 4; vol=11 -> 3 then 2; vol=00 -> 0.
- freq=11'h7FF for 40 cycles -> idx wraps 31->0; wave_addr cycles 0..15 then 0.
- ff1b_wr len_data=8'hFE, ff1e_d6=1, trig, two len_tick strobes -> ch3_active falls on the second tick; ch3_out=0 from the next cycle.
- nff1a_d7=1 together with trig -> ch3_active stays 0. Same-cycle trig plus expiring len_tick -> ch3_active=1 and len_cnt=0.

Source files
------------

// File: rtl/ch3_pkg.sv
// Shared definitions for the channel 3 wave playback engine.
// Holds the output-level code type, the timer terminal value, the wave
// position index width, and the level-shift helper used by the DAC stage.
package ch3_pkg;

  // Terminal count of the frequency timer; reaching it advances the wave
  // position and reloads the timer from the CPU-written frequency.
  localparam logic [10:0] FREQ_MAX = 11'h7FF;

  // Wave position index: 32 nibbles, the upper four bits pick the byte.
  localparam int IDX_W = 5;

  // Output level as written to FF1C bits 6:5.
  typedef enum logic [1:0] {
    VOL_MUTE = 2'b00,
    VOL_100  = 2'b01,
    VOL_50   = 2'b10,
    VOL_25   = 2'b11
  } vol_code_t;

  // Applies the output-level attenuation to one 4-bit wave sample.
  function automatic logic [3:0] vol_shift(input logic [3:0] nibble,
                                           input vol_code_t code);
    case (code)
      VOL_MUTE: return 4'h0;
      VOL_100:  return nibble;
      VOL_50:   return nibble >> 1;
      default:  return nibble >> 2;
    endcase
  endfunction

endpackage

// File: rtl/ch3_length_ctr.sv
// Channel 3 length counter.
// Counts up on frame-sequencer ticks when length is enabled and signals the
// top when it wraps from all-ones to zero, which silences the channel.
// Ports:
//   clk_i       - APU clock, rising edge
//   rst_ni      - asynchronous active-low reset
//   load_i      - FF1B write strobe, loads load_val_i
//   load_val_i  - FF1B data
//   tick_i      - 256 Hz frame-sequencer strobe
//   en_i        - length enable (FF1E bit 6)
//   trig_i      - effective trigger (already qualified by DAC power)
//   expire_o    - one-cycle pulse when the counter wraps on a tick
module ch3_length_ctr
  import ch3_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic [LEN_W-1:0] load_val_i,
  input  logic             tick_i,
  input  logic             en_i,
  input  logic             trig_i,
  output logic             expire_o
);

  logic [LEN_W-1:0] lenCnt_q;
  logic [LEN_W-1:0] lenCnt_d;

  // A CPU write always wins over a same-cycle tick. A tick on an all-ones
  // counter wraps it to zero and raises expire. A trigger on an all-ones
  // counter clears it so the freshly started note gets a full length; when
  // a tick lands in the same cycle the wrap already produces zero.
  always_comb begin
    lenCnt_d = lenCnt_q;
    expire_o = 1'b0;
    if (load_i) begin
      lenCnt_d = load_val_i;
    end else if (tick_i && en_i) begin
      lenCnt_d = lenCnt_q + LEN_W'(1);
      expire_o = (lenCnt_q == '1);
    end else if (trig_i && (lenCnt_q == '1)) begin
      lenCnt_d = '0;
    end
  end

  // Counter register; keeps counting even while the channel is silent.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lenCnt_q <= '0;
    end else begin
      lenCnt_q <= lenCnt_d;
    end
  end

endmodule

// File: rtl/ch3_wave_player.sv
// Channel 3 playback engine.
// Steps the frequency timer, walks the 32-nibble wave RAM, applies the output
// level shift and runs the length counter, producing the DAC code and the
// channel-active status.
// Ports:
//   cery_2mhz   - APU 2 MHz clock, rising edge
//   napu_reset  - asynchronous active-low reset
//   nff1a_d7    - DAC power, active low
//   ff1b_wr     - FF1B write strobe, len_data valid
//   len_data    - length load value
//   ff1c_vol    - output level code
//   ff1d_freq   - frequency low byte
//   ff1e_freq   - frequency high bits
//   ff1e_d6     - length enable
//   trig        - FF1E write with bit 7 set
//   len_tick    - 256 Hz frame-sequencer strobe
//   wave_rd     - one-cycle wave RAM read request
//   wave_addr   - wave RAM byte address (offset from FF30)
//   wave_data   - wave RAM byte, valid the cycle after wave_rd
//   ch3_out     - 4-bit DAC code
//   ch3_active  - channel on status
module ch3_wave_player
  import ch3_pkg::*;
#(
  parameter int LEN_W  = 8,
  parameter int FREQ_W = 11
) (
  input  logic             cery_2mhz,
  input  logic             napu_reset,
  input  logic             nff1a_d7,
  input  logic             ff1b_wr,
  input  logic [LEN_W-1:0] len_data,
  input  logic [1:0]       ff1c_vol,
  input  logic [7:0]       ff1d_freq,
  input  logic [2:0]       ff1e_freq,
  input  logic             ff1e_d6,
  input  logic             trig,
  input  logic             len_tick,
  output logic             wave_rd,
  output logic [3:0]       wave_addr,
  input  logic [7:0]       wave_data,
  output logic [3:0]       ch3_out,
  output logic             ch3_active
);

  localparam logic [FREQ_W-1:0] TimerMax = FREQ_W'(FREQ_MAX);

  logic [FREQ_W-1:0] freqCnt_q, freqCnt_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [7:0]        sampleBuf_q, sampleBuf_d;
  logic              active_q, active_d;
  logic              waveRd_q, waveRd_d;
  logic [3:0]        waveAddr_q, waveAddr_d;
  logic              fetch_q;
  logic [3:0]        out_q, out_d;

  logic              dacOn;
  logic              trigOn;
  logic              stepNow;
  logic              lenExpire;
  logic [FREQ_W-1:0] reloadVal;
  logic [3:0]        nibble;

  assign dacOn     = ~nff1a_d7;
  assign trigOn    = trig & dacOn;
  assign reloadVal = FREQ_W'({ff1e_freq, ff1d_freq});
  assign stepNow   = dacOn & ~trig & active_q & (freqCnt_q == TimerMax);
  assign nibble    = idx_q[0] ? sampleBuf_q[3:0] : sampleBuf_q[7:4];

  ch3_length_ctr #(
    .LEN_W (LEN_W)
  ) u_length_ctr (
    .clk_i      (cery_2mhz),
    .rst_ni     (napu_reset),
    .load_i     (ff1b_wr),
    .load_val_i (len_data),
    .tick_i     (len_tick),
    .en_i       (ff1e_d6),
    .trig_i     (trigOn),
    .expire_o   (lenExpire)
  );

  // Frequency timer and wave position. A trigger restarts from the CPU
  // frequency at nibble 0. While playing, the timer counts up and on its
  // terminal value reloads and advances the position, so the frequency
  // registers are only picked up at a reload. With the DAC off, or while
  // silent, both simply hold.
  always_comb begin
    freqCnt_d = freqCnt_q;
    idx_d     = idx_q;
    if (trigOn) begin
      freqCnt_d = reloadVal;
      idx_d     = '0;
    end else if (stepNow) begin
      freqCnt_d = reloadVal;
      idx_d     = idx_q + IDX_W'(1);
    end else if (dacOn && active_q) begin
      freqCnt_d = freqCnt_q + FREQ_W'(1);
    end
  end

  // Channel status. DAC power outranks everything, then a trigger, then
  // length expiry; a trigger in the same cycle as expiry keeps it playing.
  always_comb begin
    active_d = active_q;
    if (!dacOn) begin
      active_d = 1'b0;
    end else if (trig) begin
      active_d = 1'b1;
    end else if (lenExpire) begin
      active_d = 1'b0;
    end
  end

  // Wave RAM fetch. Each position advance issues a single read of the byte
  // that holds the new nibble; the byte lands in the sample buffer one cycle
  // after the request. A trigger does not refetch, so the previous byte
  // keeps playing until the first advance brings in fresh data.
  always_comb begin
    waveRd_d    = stepNow;
    waveAddr_d  = stepNow ? idx_d[IDX_W-1:1] : waveAddr_q;
    sampleBuf_d = fetch_q ? wave_data : sampleBuf_q;
  end

  // DAC code, registered from the current buffer, position and level. It is
  // gated with the next channel status so the output drops together with
  // ch3_active rather than a cycle later.
  always_comb begin
    out_d = active_d ? vol_shift(nibble, vol_code_t'(ff1c_vol)) : 4'h0;
  end

  // State registers; reset returns everything to idle at once, which also
  // cancels any pending read so no request escapes around reset.
  always_ff @(posedge cery_2mhz or negedge napu_reset) begin
    if (!napu_reset) begin
      freqCnt_q   <= '0;
      idx_q       <= '0;
      sampleBuf_q <= '0;
      active_q    <= 1'b0;
      waveRd_q    <= 1'b0;
      waveAddr_q  <= '0;
      fetch_q     <= 1'b0;
      out_q       <= '0;
    end else begin
      freqCnt_q   <= freqCnt_d;
      idx_q       <= idx_d;
      sampleBuf_q <= sampleBuf_d;
      active_q    <= active_d;
      waveRd_q    <= waveRd_d;
      waveAddr_q  <= waveAddr_d;
      fetch_q     <= waveRd_q;
      out_q       <= out_d;
    end
  end

  assign wave_rd    = waveRd_q;
  assign wave_addr  = waveAddr_q;
  assign ch3_out    = out_q;
  assign ch3_active = active_q;

endmodule
